// File: rtl/clk_div_ctrl_if.sv
// Config handshake bundle for clk_div_ctrl.
// Master drives a request; slave answers with ready.
interface clk_div_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             valid;
  logic             ready;
  logic             en;
  logic [WIDTH-1:0] div;

  modport master (
    output valid,
    output en,
    output div,
    input  ready
  );

  modport slave (
    input  valid,
    input  en,
    input  div,
    output ready
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable glitch-free clock divider.
// Config changes take effect only on a period boundary.
module clk_div_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEF_DIV    = 30,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  clk_div_ctrl_if.slave    cfg,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] cur_div
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_CL =
    (DEF_DIV < 2) ? DIV_MIN : WIDTH'(DEF_DIV);

  function automatic logic [WIDTH-1:0] clamp(
    input logic [WIDTH-1:0] d
  );
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             pen_q, pen_d;
  logic [WIDTH-1:0] pdiv_q, pdiv_d;
  logic             boot_q;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             run_q, run_d;
  logic             rdy_q, rdy_d;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] half_d;

  assign accept  = cfg.valid & rdy_q;
  assign last    = (cnt_q == div_q - WIDTH'(1));
  assign cnt_inc = last ? '0 : cnt_q + WIDTH'(1);

  // Next state: sequencer and period counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pen_d   = pen_q;
    pdiv_d  = pdiv_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (AUTO_START && boot_q) begin
          state_d = RUN;
          div_d   = DEF_CL;
        end else if (accept && cfg.en) begin
          state_d = RUN;
          div_d   = clamp(cfg.div);
        end
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (accept) begin
          if (last) begin
            // boundary: apply now, skip PEND
            cnt_d = '0;
            if (cfg.en) begin
              div_d = clamp(cfg.div);
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = PEND;
            pen_d   = cfg.en;
            pdiv_d  = clamp(cfg.div);
          end
        end
      end
      PEND: begin
        cnt_d = cnt_inc;
        if (last) begin
          cnt_d = '0;
          pen_d = 1'b0;
          if (pen_q) begin
            state_d = RUN;
            div_d   = pdiv_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs track the next cycle's count
  always_comb begin
    run_d  = (state_d != IDLE);
    half_d = div_d >> 1;
    clk_d  = run_d & (cnt_d < half_d);
    tick_d = run_d &
             (cnt_d == div_d - WIDTH'(1));
    rdy_d  = (state_d != PEND);
  end

  // State and output registers, sync reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DEF_CL;
      pen_q   <= 1'b0;
      pdiv_q  <= '0;
      boot_q  <= 1'b1;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pen_q   <= pen_d;
      pdiv_q  <= pdiv_d;
      boot_q  <= 1'b0;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      run_q   <= run_d;
      rdy_q   <= rdy_d;
    end
  end

  assign cfg.ready = rdy_q;
  assign clk_out   = clk_q;
  assign tick      = tick_q;
  assign running   = run_q;
  assign cur_div   = div_q;

endmodule
